// File: rtl/llsc_link_unit.sv
// LL/SC reservation unit: keeps the committed link bit and linked word,
// forwards the WB-stage update to an SC in MEM and gates the SC store.
module llsc_link_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ll_req,
  input  logic              mem_sc_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              sc_success,
  output logic              ram_we_gate,
  output logic              llbit,
  output logic [ADDR_W-1:0] link_addr
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_LL   = 2'd1;
  localparam logic [1:0] OP_SC   = 2'd2;

  logic [1:0]        wb_op_r;
  logic [WORD_W-1:0] wb_word_r;
  logic              llbit_r;
  logic [WORD_W-1:0] link_word_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        wb_op_s;
  logic              llbit_s;
  logic [WORD_W-1:0] link_word_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              timeout_hit_s;
  logic              eff_base_s;
  logic              eff_s;
  logic [WORD_W-1:0] eff_word_s;
  logic              sc_success_s;
  logic              ram_we_gate_s;

  logic [WORD_W-1:0] mem_word_s;
  logic [WORD_W-1:0] snoop_word_s;
  logic              unused_low_bits_s;

  assign mem_word_s        = mem_addr[ADDR_W-1:2];
  assign snoop_word_s      = snoop_addr[ADDR_W-1:2];
  assign unused_low_bits_s = ^{mem_addr[1:0], snoop_addr[1:0]};

  function automatic logic snoop_hits(input logic              we,
                                      input logic [WORD_W-1:0] s_word,
                                      input logic [WORD_W-1:0] l_word);
    return we && (s_word == l_word);
  endfunction

  // Op that leaves MEM this cycle; LL wins over an illegal LL+SC pair.
  always_comb begin
    wb_op_s = OP_NONE;
    if (flush || mem_stall) begin
      wb_op_s = OP_NONE;
    end else if (mem_ll_req) begin
      wb_op_s = OP_LL;
    end else if (mem_sc_req) begin
      wb_op_s = OP_SC;
    end else begin
      wb_op_s = OP_NONE;
    end
  end

  // WB pending slot; address kept only when a real op advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_op_r   <= OP_NONE;
      wb_word_r <= {WORD_W{1'b0}};
    end else if (flush || mem_stall) begin
      wb_op_r   <= wb_op_s;
      wb_word_r <= wb_word_r;
    end else begin
      wb_op_r   <= wb_op_s;
      wb_word_r <= mem_word_s;
    end
  end

  // Committed link next-state in priority order: flush, WB LL, WB SC, snoop, timeout.
  always_comb begin
    llbit_s       = llbit_r;
    link_word_s   = link_word_r;
    timeout_hit_s = TIMEOUT_EN && llbit_r && (cnt_r == CNT_LAST);
    if (flush) begin
      llbit_s = 1'b0;
    end else begin
      case (wb_op_r)
        OP_LL: begin
          link_word_s = wb_word_r;
          llbit_s     = ~snoop_hits(snoop_we, snoop_word_s, wb_word_r);
        end
        OP_SC: begin
          llbit_s = 1'b0;
        end
        default: begin
          if (snoop_hits(snoop_we, snoop_word_s, link_word_r)) begin
            llbit_s = 1'b0;
          end else if (timeout_hit_s) begin
            llbit_s = 1'b0;
          end else begin
            llbit_s = llbit_r;
          end
        end
      endcase
    end
  end

  // Reservation age: restarts on a committed LL, idles at zero while unlinked.
  always_comb begin
    cnt_s = {CNT_W{1'b0}};
    if (!llbit_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else if (!flush && (wb_op_r == OP_LL)) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Committed reservation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_r     <= 1'b0;
      link_word_r <= {WORD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      llbit_r     <= llbit_s;
      link_word_r <= link_word_s;
      cnt_r       <= cnt_s;
    end
  end

  // Link as seen by an SC in MEM, including the not-yet-committed WB op.
  always_comb begin
    eff_base_s = llbit_r;
    eff_word_s = link_word_r;
    case (wb_op_r)
      OP_LL: begin
        eff_base_s = 1'b1;
        eff_word_s = wb_word_r;
      end
      OP_SC: begin
        eff_base_s = 1'b0;
        eff_word_s = wb_word_r;
      end
      default: begin
        eff_base_s = llbit_r;
        eff_word_s = link_word_r;
      end
    endcase
    if (flush || snoop_hits(snoop_we, snoop_word_s, eff_word_s)) begin
      eff_s = 1'b0;
    end else begin
      eff_s = eff_base_s;
    end
  end

  // SC verdict is combinational so a stalled SC re-evaluates every cycle.
  always_comb begin
    sc_success_s  = 1'b0;
    ram_we_gate_s = 1'b1;
    if (mem_sc_req && !mem_ll_req && eff_s && (mem_word_s == eff_word_s)) begin
      sc_success_s = 1'b1;
    end else begin
      sc_success_s = 1'b0;
    end
    ram_we_gate_s = ~(mem_sc_req & ~sc_success_s);
  end

  assign sc_success  = sc_success_s;
  assign ram_we_gate = ram_we_gate_s;
  assign llbit       = llbit_r;
  assign link_addr   = {link_word_r, 2'b00};

endmodule

// File: doc/llsc_link_unit.md
Name: llsc_link_unit

Overview:
- Memory-side responder for the LL/SC protocol.
- Holds the link bit and the linked word address, which are committed at write-back. Forwards pending WB-stage updates to an SC in MEM.
- Decides SC success and gates the SC store to the data RAM.
- Clears the link on a pipeline flush (exception/eret), on a snooped write to the linked word, or on a reservation timeout.
- Sits beside the MEM/WB stages and in front of the data RAM write enable.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 1024, cycles a link may stay set before auto-clear; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_ll_req  input  1  LL instruction present in MEM this cycle.
- mem_sc_req  input  1  SC instruction present in MEM this cycle.
- mem_addr  input  ADDR_W  effective byte address of the MEM-stage LL/SC.
- mem_stall  input  1  MEM stage stalled; WB receives a bubble.
- flush  input  1  pipeline flush (exception/eret); kills MEM and WB.
- snoop_we  input  1  write by another master, or a non-SC store, to data memory.
- snoop_addr  input  ADDR_W  byte address of that write.
- sc_success  output  1  SC in MEM will succeed; drives rt=1 and the store enable.
- ram_we_gate  output  1  1 unless mem_sc_req and not sc_success.
- llbit  output  1  committed link bit.
- link_addr  output  ADDR_W  committed linked address, bits [1:0] forced 0.

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - llbit=0, link_addr=0, wb_op=NONE, wb_addr=0, timeout counter=0.
  - Outputs after reset: sc_success=0, ram_we_gate=1.
- All address comparisons are word granular: addr[ADDR_W-1:2].
- WB pending register (wb_op in {NONE, LL, SC}, wb_addr), on each edge:
  - flush: wb_op<=NONE.
  - else if mem_stall: wb_op<=NONE (bubble).
  - else: wb_op<=LL if mem_ll_req, SC if mem_sc_req, else NONE; wb_addr<=mem_addr.
  - mem_ll_req and mem_sc_req together is illegal; LL wins, SC is treated as absent (sc_success=0).
- Committed state update per edge, priority highest first:
  1. flush: llbit<=0.
  2. wb_op==LL: llbit<=1, link_addr<=wb_addr, counter<=0. A snoop to wb_addr's word in the same cycle overrides this, giving llbit<=0.
  3. wb_op==SC: llbit<=0, whether the SC succeeded or failed.
  4. snoop_we and snoop word == link_addr word: llbit<=0.
  5. TIMEOUT_CYCLES!=0, llbit=1, counter==TIMEOUT_CYCLES-1: llbit<=0.
  - The counter increments while llbit=1 and is held at 0 while llbit=0.
- Forwarded effective link (combinational, used by SC in MEM):
  - wb_op==LL: eff=1, eff_addr=wb_addr.
  - wb_op==SC: eff=0.
  - else: eff=llbit, eff_addr=link_addr.
  - A same-cycle snoop_we matching the eff_addr word forces eff=0.
  - flush forces eff=0.
- sc_success = mem_sc_req & ~mem_ll_req & eff & (mem_addr word == eff_addr word). Combinational, zero latency.
- ram_we_gate = ~(mem_sc_req & ~sc_success).
- While mem_stall is held, the SC result is recomputed every cycle. A snoop arriving during the stall can turn success into failure before the SC advances.
- A link update becomes visible in llbit one edge after the LL leaves MEM. A back-to-back SC sees it through forwarding.

Test Plan:
- LL 0x0000 then SC 0x0000 next cycle (forward from WB) -> sc_success=1, ram_we_gate=1. After the SC commits, llbit=0.
- LL 0x0000, then SC 0x0000 three cycles later with no intervening events -> sc_success=1. Repeat the SC immediately -> sc_success=0, ram_we_gate=0.
- LL 0x0004, then SC 0x0008 -> sc_success=0; after commit llbit=0 and link_addr stays 0x0004.
- LL 0x0000; snoop_we to 0x0002 (same word) one cycle before SC 0x0000 -> llbit=0 and SC fails. A snoop to 0x0004 instead -> SC succeeds.
- LL 0x0000, then flush asserted in the SC's MEM cycle -> sc_success=0 and llbit=0. Separately, rst asserted with llbit=1 -> llbit=0 and link_addr=0 on the next edge.
- TIMEOUT_CYCLES=4: LL 0x0000 commits -> llbit falls 4 edges after being set, and a subsequent SC 0x0000 fails. With TIMEOUT_CYCLES=0, llbit stays 1 for 2000 cycles.
